// File: rtl/npu_cube_csa_stage_if.sv
// Handshake bundle for one carry-save reduction stage: operand side (in_*) and
// result side (out_*). The stage takes the slave view; its neighbour takes master.
interface npu_cube_csa_stage_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned INW   = 10,
  parameter int unsigned W     = 12
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*INW-1:0]   in_a;
  logic [LANES*INW-1:0]   in_b;
  logic [LANES*INW-1:0]   in_c;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*W-1:0]     out_sum;
  logic [LANES*W-1:0]     out_carry;

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/npu_cube_csa_stage.sv
// Pipelined 3:2 carry-save stage, LANES lanes, valid/ready registered output.
// Optional macro NPU_CUBE_CSA_SKID_EN adds a skid register and a registered in_ready.
module npu_cube_csa_stage #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned INW    = 10,
  parameter int unsigned W      = 12,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  npu_cube_csa_stage_if.slave    bus
);

  logic [LANES*W-1:0] nxt_sum;
  logic [LANES*W-1:0] nxt_carry;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [INW-1:0] a, b, c;
    logic [W-1:0]   xa, xb, xc, maj;

    assign a = bus.in_a[k*INW +: INW];
    assign b = bus.in_b[k*INW +: INW];
    assign c = bus.in_c[k*INW +: INW];

    if (SIGNED) begin : g_sext
      assign xa = W'(signed'(a));
      assign xb = W'(signed'(b));
      assign xc = W'(signed'(c));
    end else begin : g_zext
      assign xa = W'(a);
      assign xb = W'(b);
      assign xc = W'(c);
    end

    assign maj                   = (xa & xb) | (xa & xc) | (xb & xc);
    assign nxt_sum[k*W +: W]     = xa ^ xb ^ xc;
    // Majority MSB falls off the top: the pair only has to agree modulo 2^W.
    assign nxt_carry[k*W +: W]   = maj << 1;
  end

  logic               accept;
  logic               drain;
  logic               main_valid;
  logic [LANES*W-1:0] main_sum;
  logic [LANES*W-1:0] main_carry;

  assign drain = main_valid && bus.out_ready;

`ifdef NPU_CUBE_CSA_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state;
  logic               ready_q;
  logic [LANES*W-1:0] skid_sum;
  logic [LANES*W-1:0] skid_carry;

  assign accept       = bus.in_valid && ready_q;
  assign bus.in_ready = ready_q;

  // The skid slot catches the beat accepted in the cycle out_ready dropped,
  // which is what lets in_ready come from a flop instead of from out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ready_q    <= 1'b1;
      main_valid <= 1'b0;
      main_sum   <= '0;
      main_carry <= '0;
      skid_sum   <= '0;
      skid_carry <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_sum   <= nxt_sum;
            main_carry <= nxt_carry;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_sum   <= nxt_sum;
            skid_carry <= nxt_carry;
            ready_q    <= 1'b0;
            state      <= TWO;
          end else if (accept && drain) begin
            main_sum   <= nxt_sum;
            main_carry <= nxt_carry;
          end else if (drain) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_sum   <= skid_sum;
            main_carry <= skid_carry;
            ready_q    <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          ready_q    <= 1'b1;
          main_valid <= 1'b0;
        end
      endcase
    end
  end
`else
  assign bus.in_ready = !main_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_sum   <= '0;
      main_carry <= '0;
    end else if (accept) begin
      main_sum   <= nxt_sum;
      main_carry <= nxt_carry;
      main_valid <= 1'b1;
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end
`endif

  assign bus.out_valid = main_valid;
  assign bus.out_sum   = main_sum;
  assign bus.out_carry = main_carry;

endmodule

// File: tb/tb_npu_cube_csa_stage.sv
// Scoreboard bench: an unsigned and a signed stage driven with identical stimulus,
// checked against an arithmetic bit-count model and an occupancy model of the handshake.
module tb_npu_cube_csa_stage;
  localparam int unsigned LANES = 8;
  localparam int unsigned INW   = 10;
  localparam int unsigned W     = 12;
  localparam int unsigned M     = 1 << W;

`ifdef NPU_CUBE_CSA_SKID_EN
  localparam int BP_ACCEPTS = 2;
`else
  localparam int BP_ACCEPTS = 1;
`endif

  typedef logic [LANES*INW-1:0] vin_t;
  typedef logic [LANES*W-1:0]   vout_t;

  typedef struct {
    vin_t  a, b, c;
    vout_t sum_u, carry_u, sum_s, carry_s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  npu_cube_csa_stage_if #(.LANES(LANES), .INW(INW), .W(W)) u_bus ();
  npu_cube_csa_stage_if #(.LANES(LANES), .INW(INW), .W(W)) s_bus ();

  npu_cube_csa_stage #(.LANES(LANES), .INW(INW), .W(W), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_bus)
  );
  npu_cube_csa_stage #(.LANES(LANES), .INW(INW), .W(W), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst_n(rst_n), .bus(s_bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   outs   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Operand value as an integer taken modulo 2^W.
  function automatic int unsigned ext(input bit sgn, input logic [INW-1:0] v);
    int x;
    x = int'(v);
    if (sgn && v[INW-1]) x = x - (1 << INW);
    x = ((x % int'(M)) + int'(M)) % int'(M);
    return int'(x);
  endfunction

  // Column-wise bit count: parity is the sum bit, count>=2 carries into the next column.
  function automatic void model(input bit sgn, input vin_t a, b, c, output vout_t s, output vout_t cy);
    s  = '0;
    cy = '0;
    for (int k = 0; k < LANES; k++) begin
      int unsigned va, vb, vc, cnt;
      va = ext(sgn, a[k*INW +: INW]);
      vb = ext(sgn, b[k*INW +: INW]);
      vc = ext(sgn, c[k*INW +: INW]);
      for (int i = 0; i < W; i++) begin
        cnt = ((va >> i) & 1) + ((vb >> i) & 1) + ((vc >> i) & 1);
        s[k*W + i] = (cnt % 2) == 1;
        if (i + 1 < W) cy[k*W + i + 1] = cnt >= 2;
      end
    end
  endfunction

  function automatic bit invariant_ok(input bit sgn, input vin_t a, b, c, input vout_t s, cy);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      int unsigned lhs, rhs;
      lhs = (int'(s[k*W +: W]) + int'(cy[k*W +: W])) % M;
      rhs = (ext(sgn, a[k*INW +: INW]) + ext(sgn, b[k*INW +: INW]) + ext(sgn, c[k*INW +: INW])) % M;
      if (lhs != rhs) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic vin_t fill(input logic [INW-1:0] v);
    vin_t r;
    for (int k = 0; k < LANES; k++) r[k*INW +: INW] = v;
    return r;
  endfunction

  function automatic vin_t rand_vec();
    vin_t r;
    for (int k = 0; k < LANES; k++) begin
      case ($urandom_range(0, 7))
        0:       r[k*INW +: INW] = '1;
        1:       r[k*INW +: INW] = '0;
        2:       r[k*INW +: INW] = INW'(1 << (INW - 1));
        default: r[k*INW +: INW] = INW'($urandom_range(0, (1 << INW) - 1));
      endcase
    end
    return r;
  endfunction

  // Called at posedge+1; returns at the next posedge+1. The expected beat enters
  // the scoreboard at the edge that transfers it, so queue size == stage occupancy.
  task automatic drive(input bit v, input vin_t a, b, c, input bit ordy, output bit acc);
    exp_t e;
    u_bus.in_valid = v;  s_bus.in_valid = v;
    u_bus.in_a = a;      s_bus.in_a = a;
    u_bus.in_b = b;      s_bus.in_b = b;
    u_bus.in_c = c;      s_bus.in_c = c;
    u_bus.out_ready = ordy;
    s_bus.out_ready = ordy;
    @(negedge clk);
    acc = rst_n && v && u_bus.in_ready;
    @(posedge clk);
    if (acc) begin
      e.a = a; e.b = b; e.c = c;
      model(1'b0, a, b, c, e.sum_u, e.carry_u);
      model(1'b1, a, b, c, e.sum_s, e.carry_s);
      q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, rand_vec(), rand_vec(), rand_vec(), 1'b1, acc);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid_u"}, u_bus.out_valid, 1'b0);
    chk({tag, "_valid_s"}, s_bus.out_valid, 1'b0);
    chk({tag, "_sum_u"},   u_bus.out_sum,   '0);
    chk({tag, "_carry_u"}, u_bus.out_carry, '0);
    chk({tag, "_sum_s"},   s_bus.out_sum,   '0);
    chk({tag, "_carry_s"}, s_bus.out_carry, '0);
    chk({tag, "_ready_u"}, u_bus.in_ready,  1'b1);
    chk({tag, "_ready_s"}, s_bus.in_ready,  1'b1);
  endtask

  // Monitor
  initial begin
    bit    stall;
    bit    exp_valid, exp_rdy;
    vout_t hs_u, hc_u, hs_s, hc_s;
    exp_t  e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      exp_valid = q.size() > 0;
`ifdef NPU_CUBE_CSA_SKID_EN
      exp_rdy = q.size() < 2;
`else
      exp_rdy = (q.size() == 0) || u_bus.out_ready;
`endif
      chk("out_valid_u", u_bus.out_valid, exp_valid);
      chk("out_valid_s", s_bus.out_valid, exp_valid);
      chk("in_ready_u",  u_bus.in_ready,  exp_rdy);
      chk("in_ready_s",  s_bus.in_ready,  exp_rdy);
      if (stall) begin
        chk("stall_sum_u",   u_bus.out_sum,   hs_u);
        chk("stall_carry_u", u_bus.out_carry, hc_u);
        chk("stall_sum_s",   s_bus.out_sum,   hs_s);
        chk("stall_carry_s", s_bus.out_carry, hc_s);
      end
      if (u_bus.out_valid && u_bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=out_valid required=empty_stage sum=%0h", u_bus.out_sum);
        end else begin
          e = q.pop_front();
          outs++;
          chk("sum_u",   u_bus.out_sum,   e.sum_u);
          chk("carry_u", u_bus.out_carry, e.carry_u);
          chk("sum_s",   s_bus.out_sum,   e.sum_s);
          chk("carry_s", s_bus.out_carry, e.carry_s);
          chk("invariant_u", invariant_ok(1'b0, e.a, e.b, e.c, u_bus.out_sum, u_bus.out_carry), 1'b1);
          chk("invariant_s", invariant_ok(1'b1, e.a, e.b, e.c, s_bus.out_sum, s_bus.out_carry), 1'b1);
        end
      end
      stall = u_bus.out_valid && !u_bus.out_ready;
      hs_u = u_bus.out_sum;  hc_u = u_bus.out_carry;
      hs_s = s_bus.out_sum;  hc_s = s_bus.out_carry;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Stimulus
  initial begin
    bit acc;
    int n, o0, guard;
    vin_t bp_a [3];

    rst_n = 1'b0;
    u_bus.in_valid = 1'b1; s_bus.in_valid = 1'b1;
    u_bus.in_a = '1; u_bus.in_b = '1; u_bus.in_c = '1;
    s_bus.in_a = '1; s_bus.in_b = '1; s_bus.in_c = '1;
    u_bus.out_ready = 1'b0; s_bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // All-ones unsigned corner
    drive(1'b1, fill(10'h3FF), fill(10'h3FF), fill(10'h3FF), 1'b1, acc);
    chk("t1_accept", acc, 1'b1);
    chk("t1_sum",   u_bus.out_sum[W-1:0],   12'h3FF);
    chk("t1_carry", u_bus.out_carry[W-1:0], 12'h7FE);
    chk("t1_total", 13'(u_bus.out_sum[W-1:0]) + 13'(u_bus.out_carry[W-1:0]), 13'hBFD);

    // -1 + 1 + 0 with sign extension
    drive(1'b1, fill(10'h3FF), fill(10'h001), fill(10'h000), 1'b1, acc);
    chk("t2_accept", acc, 1'b1);
    chk("t2_sum",   s_bus.out_sum[W-1:0],   12'hFFE);
    chk("t2_carry", s_bus.out_carry[W-1:0], 12'h002);
    chk("t2_total", W'(s_bus.out_sum[W-1:0] + s_bus.out_carry[W-1:0]), 12'h000);
    idle(2);

    // Back-pressure: three beats against a stalled consumer
    bp_a[0] = fill(10'd1); bp_a[1] = fill(10'd2); bp_a[2] = fill(10'd3);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      drive(n < 3, bp_a[n < 3 ? n : 2], '0, '0, 1'b0, acc);
      if (acc) n++;
    end
    chk("bp_accepted", n, BP_ACCEPTS);
    chk("bp_in_ready", u_bus.in_ready, 1'b0);
    guard = 0;
    while (n < 3 && guard < 20) begin
      drive(1'b1, bp_a[n], '0, '0, 1'b1, acc);
      if (acc) n++;
      guard++;
    end
    chk("bp_all_sent", n, 3);
    idle(3);
    chk("bp_drained", q.size(), 0);

    // Full throughput
    n = 0;
    o0 = outs;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, rand_vec(), rand_vec(), rand_vec(), 1'b1, acc);
      if (acc) n++;
    end
    idle(1);
    chk("tp_accepts", n, 100);
    chk("tp_outputs", outs - o0, 100);

    // Reset with the stage full
    for (int i = 0; i < 4; i++) drive(1'b1, rand_vec(), rand_vec(), rand_vec(), 1'b0, acc);
    chk("mid_full", q.size(), BP_ACCEPTS);
    rst_n = 1'b0;
    u_bus.in_valid = 1'b1; s_bus.in_valid = 1'b1;
    u_bus.out_ready = 1'b1; s_bus.out_ready = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check_reset_state("midreset");
    rst_n = 1'b1;
    idle(4);

    // Random handshake toggling
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), rand_vec(), rand_vec(), rand_vec(),
            $urandom_range(0, 3) != 0, acc);
    idle(4);
    chk("final_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_cube_csa_stage.md
# npu_cube_csa_stage

Parametrised, pipelined carry-save (3:2) reduction stage for the NPU cube adder tree. Each of `LANES` lanes compresses three `INW`-bit operands into one `W`-bit sum vector and one `W`-bit carry vector, with optional sign extension. Results are registered behind a valid/ready handshake. Stages chain back-to-back to form a multi-level tree with back-pressure, replacing fixed-width, purely combinational level blocks.

## Interface
- `LANES`, 8, number of independent compressor lanes
- `INW`, 10, operand width per lane
- `W`, 12, output width per lane; must satisfy `W >= INW`
- `SIGNED`, 0, 1 = sign-extend operands from `INW` to `W`; 0 = zero-extend
- `clk`  in  1  clock; all logic rising-edge
- `rst_n`  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_a`  in  LANES*INW  operand A, lane k at [k*INW +: INW]
- `in_b`  in  LANES*INW  operand B, same packing
- `in_c`  in  LANES*INW  operand C, same packing
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts beat
- `out_sum`  out  LANES*W  sum vectors, lane k at [k*W +: W]
- `out_carry`  out  LANES*W  carry vectors, already shifted left by one, same packing

## Operation
- Per lane: extend a, b, c to `W` bits (replicate bit INW-1 if `SIGNED`, else zeros).
- sum = a^b^c; carry = ((a&b)|(a&c)|(b&c)) << 1, truncated to `W` bits (bit 0 = 0; majority MSB dropped).
- Invariant per lane: sum + carry == a + b + c mod 2^W.
- Input transfer when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
- Output data is stable while `out_valid && !out_ready`; no beat is dropped or duplicated, and order is preserved.
- Default build: one output register. `in_ready = !out_valid || out_ready` (combinational from `out_ready`).
- On accept, register the computed lanes and set `out_valid`. On output transfer with no accept, clear `out_valid`.
- Simultaneous accept and output transfer replaces the register contents; `out_valid` stays 1.

## Timing
- Latency: 1 cycle from input transfer to `out_valid` high with data.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- Reset (while `rst_n` low, and on the first edge after it rises):
  - `out_valid` = 0, `out_sum` = 0, `out_carry` = 0.
  - `in_ready` = 1 in both builds.
  - Any handshake presented during reset is ignored.
- Reset mid-operation: all held beats are discarded and the stage restarts empty.
- `in_valid` deasserted: no state change except draining.

## Configuration
- `NPU_CUBE_CSA_SKID_EN` defined:
  - Adds a skid register and makes `in_ready` a registered signal with no combinational path from `out_ready`.
  - States: EMPTY (nothing held), ONE (main full), TWO (main and skid full).
  - EMPTY --accept--> ONE.
  - ONE --accept, no drain--> TWO; ONE --drain, no accept--> EMPTY; ONE --both--> ONE.
  - TWO --drain--> ONE, with skid moving to main; no accept in TWO.
  - `in_ready` = 1 in EMPTY and ONE, 0 in TWO; `out_valid` = 1 in ONE and TWO.
  - Latency is still 1 cycle.
- Not defined: single-register behaviour described in Operation.

## Test plan
- Unsigned, INW=10, W=12: a=0x3FF, b=0x3FF, c=0x3FF, `out_ready`=1 -> next cycle sum=0x3FF, carry=0x7FE, sum+carry=0xBFD.
- SIGNED=1: a=0x3FF (-1), b=0x001, c=0x000 -> sum=0xFFE, carry=0x002, sum+carry mod 4096 = 0.
- Back-pressure: three beats (a=1, 2, 3; b=c=0) with `out_ready` low for 4 cycles:
  - Default build: `in_ready` falls after 1 accepted beat.
  - SKID build: `in_ready` falls after 2 accepted beats.
  - When `out_ready` rises, outputs arrive in order 1, 2, 3, with no loss.
- Full throughput: 100 random beats, `in_valid` and `out_ready` held high -> 100 outputs on consecutive cycles; per-lane invariant holds on every beat.
- Reset mid-stream: assert `rst_n`=0 for one cycle while in TWO/full -> `out_valid`=0 and outputs 0 next cycle, `in_ready`=1, held beats never appear.
- Random `in_valid`/`out_ready` toggling, LANES=8 -> scoreboard matches every lane modulo 2^W; data is stable while stalled.
